// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path: states, opcodes,
// mux-select encodings and the control word driven towards the datapath.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_JUMP   = 4'd10;
   localparam logic [3:0] S_ADDIEX = 4'd11;
   localparam logic [3:0] S_ADDIWB = 4'd12;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       memtoReg;
      logic       regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSource;
   } ctrl_word_t;

   function automatic logic isLegalOp(input logic [5:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between mc_ctrl (master) and the multicycle datapath (slave).
interface mc_ctrl_if #(parameter int CNT_W = 32);

   logic [5:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             PCWrite;
   logic             PCWriteCond;
   logic             IorD;
   logic             MemRead;
   logic             MemWrite;
   logic             IRWrite;
   logic             MemtoReg;
   logic             RegDst;
   logic             RegWrite;
   logic             ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic [1:0]       PCSource;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  opcode, zero, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             illegal, retired
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             illegal, retired
   );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Purely combinational state-to-control-word table; FETCH is Mealy on memory ready.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] state_i,
   input  logic       memReady_i,
   output ctrl_word_t ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.memRead = 1'b1;
            ctrl_o.aluSrcB = SRCB_FOUR;
            ctrl_o.irWrite = memReady_i;
            ctrl_o.pcWrite = memReady_i;
         end
         S_DECODE: ctrl_o.aluSrcB = SRCB_IMMSH;
         S_MEMADR, S_ADDIEX: begin
            ctrl_o.aluSrcA = 1'b1;
            ctrl_o.aluSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl_o.memRead = 1'b1;
            ctrl_o.iorD    = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.regWrite = 1'b1;
            ctrl_o.memtoReg = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.memWrite = 1'b1;
            ctrl_o.iorD     = 1'b1;
         end
         S_EXEC: begin
            ctrl_o.aluSrcA = 1'b1;
            ctrl_o.aluSrcB = SRCB_B;
            ctrl_o.aluOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.regWrite = 1'b1;
            ctrl_o.regDst   = 1'b1;
         end
         S_ADDIWB: ctrl_o.regWrite = 1'b1;
         S_BRANCH: begin
            ctrl_o.aluSrcA     = 1'b1;
            ctrl_o.aluOp       = ALUOP_SUB;
            ctrl_o.pcWriteCond = 1'b1;
            ctrl_o.pcSource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl_o.pcWrite  = 1'b1;
            ctrl_o.pcSource = PCSRC_JUMP;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset main control: state register, next-state logic,
// illegal-opcode pulse and retired-instruction counter.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic      clk,
   input  logic      rst_n,
   mc_ctrl_if.master bus_io
);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             memRdy;
   logic             retire;
   logic             unusedZero;
   ctrl_word_t       ctrl;

   // The zero flag gates PCWriteCond inside the datapath, not here.
   assign unusedZero = bus_io.zero;
   assign memRdy     = MEM_WAIT_EN ? bus_io.mem_ready : 1'b1;

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (memRdy) state_d = S_DECODE;
         S_DECODE: begin
            case (bus_io.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (bus_io.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (memRdy) state_d = S_MEMWB;
         S_MEMWR: begin
            if (memRdy) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   assign retired_d = retired_q + CNT_W'(retire);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   mc_ctrl_decode u_decode (
      .state_i    (state_q),
      .memReady_i (memRdy),
      .ctrl_o     (ctrl)
   );

   assign bus_io.PCWrite     = ctrl.pcWrite;
   assign bus_io.PCWriteCond = ctrl.pcWriteCond;
   assign bus_io.IorD        = ctrl.iorD;
   assign bus_io.MemRead     = ctrl.memRead;
   assign bus_io.MemWrite    = ctrl.memWrite;
   assign bus_io.IRWrite     = ctrl.irWrite;
   assign bus_io.MemtoReg    = ctrl.memtoReg;
   assign bus_io.RegDst      = ctrl.regDst;
   assign bus_io.RegWrite    = ctrl.regWrite;
   assign bus_io.ALUSrcA     = ctrl.aluSrcA;
   assign bus_io.ALUSrcB     = ctrl.aluSrcB;
   assign bus_io.ALUOp       = ctrl.aluOp;
   assign bus_io.PCSource    = ctrl.pcSource;
   assign bus_io.illegal     = (state_q == S_DECODE) && !isLegalOp(bus_io.opcode);
   assign bus_io.retired     = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized instruction-level bench for mc_ctrl; a second instance with a
// 3-bit counter exercises retired wrap-around.
module tb_mc_ctrl;

   typedef enum {P_IDLE, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                 P_EXEC, P_ALUWB, P_BRANCH, P_JUMP, P_ADDIEX, P_ADDIWB} phase_e;

   localparam logic [5:0] TB_R    = 6'b000000;
   localparam logic [5:0] TB_LW   = 6'b100011;
   localparam logic [5:0] TB_SW   = 6'b101011;
   localparam logic [5:0] TB_BEQ  = 6'b000100;
   localparam logic [5:0] TB_J    = 6'b000010;
   localparam logic [5:0] TB_ADDI = 6'b001000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned assertCount = 0;
   int unsigned failCount = 0;
   int unsigned modelRetired = 0;

   mc_ctrl_if #(.CNT_W(32)) ifMain ();
   mc_ctrl_if #(.CNT_W(3))  ifSmall ();

   assign ifSmall.opcode    = ifMain.opcode;
   assign ifSmall.zero      = ifMain.zero;
   assign ifSmall.mem_ready = ifMain.mem_ready;

   mc_ctrl #(.CNT_W(32), .MEM_WAIT_EN(1'b1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (ifMain)
   );

   mc_ctrl #(.CNT_W(3), .MEM_WAIT_EN(1'b1)) dutSmall (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (ifSmall)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic isLegal(input logic [5:0] op);
      return (op == TB_R) || (op == TB_LW) || (op == TB_SW) ||
             (op == TB_BEQ) || (op == TB_J) || (op == TB_ADDI);
   endfunction

   function automatic logic [15:0] packMain();
      return {ifMain.PCWrite, ifMain.PCWriteCond, ifMain.IorD, ifMain.MemRead,
              ifMain.MemWrite, ifMain.IRWrite, ifMain.MemtoReg, ifMain.RegDst,
              ifMain.RegWrite, ifMain.ALUSrcA, ifMain.ALUSrcB, ifMain.ALUOp,
              ifMain.PCSource};
   endfunction

   // Expected control word straight from the per-state output table.
   function automatic logic [15:0] expWord(input phase_e ph, input logic rdy);
      logic pcW = 0, pcWC = 0, iorD = 0, memR = 0, memW = 0, irW = 0;
      logic m2r = 0, rDst = 0, regW = 0, srcA = 0;
      logic [1:0] srcB = 2'b00, aluOp = 2'b00, pcSrc = 2'b00;
      case (ph)
         P_FETCH:  begin memR = 1; srcB = 2'b01; irW = rdy; pcW = rdy; end
         P_DECODE: srcB = 2'b11;
         P_MEMADR, P_ADDIEX: begin srcA = 1; srcB = 2'b10; end
         P_MEMRD:  begin memR = 1; iorD = 1; end
         P_MEMWB:  begin regW = 1; m2r = 1; end
         P_MEMWR:  begin memW = 1; iorD = 1; end
         P_EXEC:   begin srcA = 1; aluOp = 2'b10; end
         P_ALUWB:  begin regW = 1; rDst = 1; end
         P_ADDIWB: regW = 1;
         P_BRANCH: begin srcA = 1; aluOp = 2'b01; pcWC = 1; pcSrc = 2'b01; end
         P_JUMP:   begin pcW = 1; pcSrc = 2'b10; end
         default:  ;
      endcase
      return {pcW, pcWC, iorD, memR, memW, irW, m2r, rDst, regW, srcA, srcB, aluOp, pcSrc};
   endfunction

   task automatic applyStimulus(input phase_e ph, input logic rdy, input logic [5:0] op,
                                input logic z);
      logic retireNow;
      ifMain.mem_ready = rdy;
      ifMain.opcode    = op;
      ifMain.zero      = z;
      #1;
      checkOutput({ph.name(), ".word"}, 64'(packMain()), 64'(expWord(ph, rdy)));
      checkOutput({ph.name(), ".illegal"}, 64'(ifMain.illegal),
                  64'((ph == P_DECODE) && !isLegal(op)));
      checkOutput({ph.name(), ".retired"}, 64'(ifMain.retired), 64'(modelRetired));
      checkOutput({ph.name(), ".retiredWrap"}, 64'(ifSmall.retired), 64'(modelRetired % 8));
      checkOutput({ph.name(), ".exclusive"},
                  64'((ifMain.MemRead & ifMain.MemWrite) | (ifMain.RegWrite & ifMain.MemWrite)),
                  64'(0));
      retireNow = (ph inside {P_MEMWB, P_ALUWB, P_ADDIWB, P_BRANCH, P_JUMP}) ||
                  ((ph == P_MEMWR) && rdy);
      if (retireNow) modelRetired++;
      @(negedge clk);
   endtask

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic runInstr(input logic [5:0] op, input int fetchWaits, input int memWaits,
                           input logic z);
      for (int i = 0; i < fetchWaits; i++) applyStimulus(P_FETCH, 1'b0, op, z);
      applyStimulus(P_FETCH, 1'b1, op, z);
      applyStimulus(P_DECODE, rnd1(), op, z);
      case (op)
         TB_LW: begin
            applyStimulus(P_MEMADR, rnd1(), op, z);
            for (int i = 0; i < memWaits; i++) applyStimulus(P_MEMRD, 1'b0, op, z);
            applyStimulus(P_MEMRD, 1'b1, op, z);
            applyStimulus(P_MEMWB, rnd1(), op, z);
         end
         TB_SW: begin
            applyStimulus(P_MEMADR, rnd1(), op, z);
            for (int i = 0; i < memWaits; i++) applyStimulus(P_MEMWR, 1'b0, op, z);
            applyStimulus(P_MEMWR, 1'b1, op, z);
         end
         TB_R: begin
            applyStimulus(P_EXEC, rnd1(), op, z);
            applyStimulus(P_ALUWB, rnd1(), op, z);
         end
         TB_ADDI: begin
            applyStimulus(P_ADDIEX, rnd1(), op, z);
            applyStimulus(P_ADDIWB, rnd1(), op, z);
         end
         TB_BEQ: applyStimulus(P_BRANCH, rnd1(), op, z);
         TB_J:   applyStimulus(P_JUMP, rnd1(), op, z);
         default: ;
      endcase
   endtask

   initial begin
      logic [5:0] legalOps [6];
      logic [5:0] op;
      legalOps = '{TB_R, TB_LW, TB_SW, TB_BEQ, TB_J, TB_ADDI};
      ifMain.opcode    = 6'd0;
      ifMain.zero      = 1'b0;
      ifMain.mem_ready = 1'b1;

      @(negedge clk);
      @(negedge clk);
      checkOutput("reset.word", 64'(packMain()), 64'(0));
      checkOutput("reset.retired", 64'(ifMain.retired), 64'(0));
      checkOutput("reset.illegal", 64'(ifMain.illegal), 64'(0));
      rst_n = 1'b1;
      applyStimulus(P_IDLE, 1'b1, 6'd0, 1'b0);

      runInstr(TB_LW, 0, 0, 1'b0);
      runInstr(TB_SW, 0, 3, 1'b0);
      runInstr(TB_R, 0, 0, 1'b0);
      runInstr(TB_BEQ, 0, 0, 1'b1);
      runInstr(6'b111111, 0, 0, 1'b0);
      runInstr(TB_J, 0, 0, 1'b0);
      runInstr(TB_ADDI, 2, 0, 1'b1);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 6) == 6) begin
            do op = 6'($urandom_range(0, 63)); while (isLegal(op));
         end else begin
            op = legalOps[$urandom_range(0, 5)];
         end
         runInstr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rnd1());
      end

      // Abort a load while it waits in MEMRD; reset must clear outputs asynchronously.
      applyStimulus(P_FETCH, 1'b1, TB_LW, 1'b0);
      applyStimulus(P_DECODE, 1'b1, TB_LW, 1'b0);
      applyStimulus(P_MEMADR, 1'b1, TB_LW, 1'b0);
      ifMain.mem_ready = 1'b0;
      #1;
      checkOutput("midRd.word", 64'(packMain()), 64'(expWord(P_MEMRD, 1'b0)));
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncReset.word", 64'(packMain()), 64'(0));
      checkOutput("asyncReset.retired", 64'(ifMain.retired), 64'(0));
      checkOutput("asyncReset.retiredWrap", 64'(ifSmall.retired), 64'(0));
      modelRetired = 0;
      @(negedge clk);
      checkOutput("heldReset.word", 64'(packMain()), 64'(0));
      rst_n = 1'b1;
      applyStimulus(P_IDLE, 1'b1, TB_J, 1'b0);
      runInstr(TB_J, 1, 0, 1'b0);
      runInstr(TB_LW, 0, 2, 1'b0);
      applyStimulus(P_FETCH, 1'b0, TB_R, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
